// File: rtl/ram_burst_controller.sv
// Burst initiator for a single-port RAM with a one-cycle registered read.
// Write bursts take one word per cycle from a valid/ready stream; read bursts emit one word per cycle.
module ram_burst_controller #(
  parameter int Data_Width = 8,
  parameter int Addr_Width = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [Addr_Width-1:0] cmd_addr,
  input  logic [Addr_Width:0]   cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [Data_Width-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [Data_Width-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [Addr_Width-1:0] ram_addr,
  output logic [Data_Width-1:0] ram_wdata,
  input  logic [Data_Width-1:0] ram_rdata
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR        = 3'd1;
  localparam logic [2:0] RD_PRIME  = 3'd2;
  localparam logic [2:0] RD_STREAM = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            state_nxt_s;
  logic [Addr_Width-1:0] addr_cnt_r;
  logic [Addr_Width-1:0] addr_cnt_nxt_s;
  logic [Addr_Width:0]   remaining_r;
  logic [Addr_Width:0]   remaining_nxt_s;
  logic                  started_r;
  logic                  last_s;

  function automatic logic [Addr_Width-1:0] addr_inc(input logic [Addr_Width-1:0] a);
    return a + Addr_Width'(1);
  endfunction

  assign last_s = (remaining_r == (Addr_Width+1)'(1));

  // Next-state, address counter and remaining-word bookkeeping
  always_comb begin
    state_nxt_s     = state_r;
    addr_cnt_nxt_s  = addr_cnt_r;
    remaining_nxt_s = remaining_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && started_r) begin
          addr_cnt_nxt_s  = cmd_addr;
          remaining_nxt_s = cmd_len;
          if (cmd_len == (Addr_Width+1)'(0)) begin
            state_nxt_s = DONE;
          end else if (cmd_write) begin
            state_nxt_s = WR;
          end else begin
            state_nxt_s = RD_PRIME;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR: begin
        if (wr_valid) begin
          addr_cnt_nxt_s  = addr_inc(addr_cnt_r);
          remaining_nxt_s = remaining_r - (Addr_Width+1)'(1);
          state_nxt_s     = last_s ? DONE : WR;
        end else begin
          state_nxt_s = WR;
        end
      end
      RD_PRIME: state_nxt_s = RD_STREAM;
      RD_STREAM: begin
        if (rd_ready && last_s) begin
          state_nxt_s = DONE;
        end else if (rd_ready) begin
          addr_cnt_nxt_s  = addr_inc(addr_cnt_r);
          remaining_nxt_s = remaining_r - (Addr_Width+1)'(1);
        end else begin
          state_nxt_s = RD_STREAM;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode; while stalled in RD_STREAM the address is held so rd_data stays stable
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_r)
      IDLE: cmd_ready = started_r;
      WR: begin
        busy      = 1'b1;
        wr_ready  = 1'b1;
        ram_we    = wr_valid;
        ram_addr  = addr_cnt_r;
        ram_wdata = wr_data;
      end
      RD_PRIME: begin
        busy     = 1'b1;
        ram_addr = addr_cnt_r;
      end
      RD_STREAM: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        rd_data  = ram_rdata;
        ram_addr = (rd_ready && !last_s) ? addr_inc(addr_cnt_r) : addr_cnt_r;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // State registers; started_r keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      addr_cnt_r  <= '0;
      remaining_r <= '0;
      started_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_cnt_r  <= addr_cnt_nxt_s;
      remaining_r <= remaining_nxt_s;
      started_r   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Table-driven bench for ram_burst_controller with a behavioural registered-read RAM.
module tb_ram_burst_controller;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       ram_we;
  logic [1:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] mem [4];

  int checks = 0;
  int errors = 0;

  // flag order: cmd_ready, busy, done, wr_ready, rd_valid, ram_we
  localparam logic [5:0] F_OFF   = 6'b000000;
  localparam logic [5:0] F_IDLE  = 6'b100000;
  localparam logic [5:0] F_WR    = 6'b010100;
  localparam logic [5:0] F_WRWE  = 6'b010101;
  localparam logic [5:0] F_PRIME = 6'b010000;
  localparam logic [5:0] F_RD    = 6'b010010;
  localparam logic [5:0] F_DONE  = 6'b011000;

  logic [23:0] outs;
  assign outs = {cmd_ready, busy, done, wr_ready, rd_valid, ram_we, ram_addr, ram_wdata, rd_data};

  typedef struct {
    string       nm;
    logic        cv;
    logic        cw;
    logic [1:0]  ca;
    logic [2:0]  cl;
    logic        wv;
    logic [7:0]  wd;
    logic        rr;
    logic [23:0] exp;
  } vec_t;

  vec_t vq[$];

  ram_burst_controller #(.Data_Width(8), .Addr_Width(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM: write on ram_we, read data registered from the address of the previous cycle
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic cv, input logic cw, input logic [1:0] ca,
                     input logic [2:0] cl, input logic wv, input logic [7:0] wd, input logic rr,
                     input logic [5:0] f, input logic [1:0] ra, input logic [7:0] rwd,
                     input logic [7:0] rdd);
    vec_t v;
    v.nm = nm; v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl;
    v.wv = wv; v.wd = wd; v.rr = rr;
    v.exp = {f, ra, rwd, rdd};
    vq.push_back(v);
  endtask

  task automatic drive(input logic cv, input logic cw, input logic [1:0] ca, input logic [2:0] cl,
                       input logic wv, input logic [7:0] wd, input logic rr);
    cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_len = cl;
    wr_valid = wv; wr_data = wd; rd_ready = rr;
  endtask

  // Called just after a rising edge: one vector per clock cycle
  task automatic run_vecs();
    foreach (vq[i]) begin
      drive(vq[i].cv, vq[i].cw, vq[i].ca, vq[i].cl, vq[i].wv, vq[i].wd, vq[i].rr);
      @(negedge clk);
      check(vq[i].nm, outs, vq[i].exp);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0);

    // Reset: every output 0, cmd_ready only after the first edge past release
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_outs", outs, 24'h000000);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("release_pre_edge", outs, 24'h000000);
    @(posedge clk);
    #1;
    check("release_ready", outs, {F_IDLE, 18'h0});

    // Write burst addr 1, len 3
    add("w3_cmd",  1'b1, 1'b1, 2'd1, 3'd3, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("w3_d0",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'hA1, 1'b0, F_WRWE, 2'd1, 8'hA1, 8'h00);
    add("w3_d1",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'hB2, 1'b0, F_WRWE, 2'd2, 8'hB2, 8'h00);
    add("w3_d2",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'hC3, 1'b0, F_WRWE, 2'd3, 8'hC3, 8'h00);
    add("w3_done", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("w3_idle", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    // Wrap-around write addr 3, len 4, then read it back
    add("ww_cmd",  1'b1, 1'b1, 2'd3, 3'd4, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("ww_d0",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h10, 1'b0, F_WRWE, 2'd3, 8'h10, 8'h00);
    add("ww_d1",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h20, 1'b0, F_WRWE, 2'd0, 8'h20, 8'h00);
    add("ww_d2",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h30, 1'b0, F_WRWE, 2'd1, 8'h30, 8'h00);
    add("ww_d3",   1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h40, 1'b0, F_WRWE, 2'd2, 8'h40, 8'h00);
    add("ww_done", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("rw_cmd",  1'b1, 1'b0, 2'd3, 3'd4, 1'b0, 8'h00, 1'b1, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("rw_prime",1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_PRIME,2'd3, 8'h00, 8'h00);
    add("rw_s0",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd0, 8'h00, 8'h10);
    add("rw_s1",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd1, 8'h00, 8'h20);
    add("rw_s2",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd2, 8'h00, 8'h30);
    add("rw_s3",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd2, 8'h00, 8'h40);
    add("rw_done", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_DONE, 2'd0, 8'h00, 8'h00);
    add("rw_idle", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    // Backpressure read addr 0, len 4; mem is now 20,30,40,10
    add("rb_cmd",  1'b1, 1'b0, 2'd0, 3'd4, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("rb_prime",1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_PRIME,2'd0, 8'h00, 8'h00);
    add("rb_s0",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd1, 8'h00, 8'h20);
    add("rb_s1",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd2, 8'h00, 8'h30);
    add("rb_stall0",1'b0,1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_RD,   2'd2, 8'h00, 8'h40);
    add("rb_stall1",1'b0,1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_RD,   2'd2, 8'h00, 8'h40);
    add("rb_s2",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd3, 8'h00, 8'h40);
    add("rb_s3",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd3, 8'h00, 8'h10);
    add("rb_done", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("rb_idle", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    // Zero-length command, then a command presented during an active burst
    add("z_cmd",   1'b1, 1'b1, 2'd2, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("z_done",  1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h99, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("z_idle",  1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("b_cmd",   1'b1, 1'b1, 2'd0, 3'd2, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("b_stall", 1'b1, 1'b0, 2'd2, 3'd3, 1'b0, 8'hEE, 1'b0, F_WR,   2'd0, 8'hEE, 8'h00);
    add("b_d0",    1'b1, 1'b0, 2'd2, 3'd3, 1'b1, 8'h5A, 1'b0, F_WRWE, 2'd0, 8'h5A, 8'h00);
    add("b_d1",    1'b1, 1'b0, 2'd2, 3'd3, 1'b1, 8'h5B, 1'b0, F_WRWE, 2'd1, 8'h5B, 8'h00);
    add("b_done",  1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("b_idle0", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("b_idle1", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    // Fill memory with zeros
    add("f_cmd",   1'b1, 1'b1, 2'd0, 3'd4, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("f_d0",    1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h00, 1'b0, F_WRWE, 2'd0, 8'h00, 8'h00);
    add("f_d1",    1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h00, 1'b0, F_WRWE, 2'd1, 8'h00, 8'h00);
    add("f_d2",    1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h00, 1'b0, F_WRWE, 2'd2, 8'h00, 8'h00);
    add("f_d3",    1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h00, 1'b0, F_WRWE, 2'd3, 8'h00, 8'h00);
    add("f_done",  1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("f_idle",  1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    run_vecs();

    // Reset in the middle of a write burst after two words
    drive(1'b1, 1'b1, 2'd0, 3'd4, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 8'h55, 1'b0);
    @(posedge clk);
    #1;
    wr_data = 8'h66;
    @(posedge clk);
    #1;
    wr_data = 8'h77;
    #2;
    check("mr_pre_reset", outs, {F_WRWE, 2'd2, 8'h77, 8'h00});
    reset_n = 1'b0;
    #1;
    check("mr_reset_now", outs, 24'h000000);
    repeat (2) begin
      @(negedge clk);
      check("mr_reset_hold", outs, 24'h000000);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("mr_release", outs, 24'h000000);
    @(posedge clk);
    #1;
    check("mr_no_done", outs, {F_IDLE, 18'h0});

    add("mr_cmd",  1'b1, 1'b0, 2'd0, 3'd4, 1'b0, 8'h00, 1'b1, F_IDLE, 2'd0, 8'h00, 8'h00);
    add("mr_prime",1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_PRIME,2'd0, 8'h00, 8'h00);
    add("mr_s0",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd1, 8'h00, 8'h55);
    add("mr_s1",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd2, 8'h00, 8'h66);
    add("mr_s2",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd3, 8'h00, 8'h00);
    add("mr_s3",   1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b1, F_RD,   2'd3, 8'h00, 8'h00);
    add("mr_done", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_DONE, 2'd0, 8'h00, 8'h00);
    add("mr_idle", 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 8'h00, 1'b0, F_IDLE, 2'd0, 8'h00, 8'h00);
    run_vecs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_controller.md
Name: ram_burst_controller

Overview:
- Burst initiator that drives the single-port RAM's write/read enable, address and write data, and consumes its read data.
- Accepts one command at a time: write or read, base address, length.
- Write bursts: data comes in on a valid/ready stream and is written at one word per cycle.
- Read bursts: words go out on a valid/ready stream at one word per cycle. The RAM's one-cycle registered-address read latency and downstream backpressure are handled inside this block.

Parameters:
- Data_Width, 8, RAM word width.
- Addr_Width, 2, RAM address width; depth is 2**Addr_Width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  Addr_Width  burst base address.
- cmd_len  in  Addr_Width+1  word count, 0..2**Addr_Width.
- wr_valid  in  1  write data valid.
- wr_ready  out  1  write data accepted.
- wr_data  in  Data_Width  write data.
- rd_valid  out  1  read data valid.
- rd_ready  in  1  downstream accepts read data.
- rd_data  out  Data_Width  read data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at burst end.
- ram_we  out  1  to the RAM write/read enable.
- ram_addr  out  Addr_Width  to the RAM address.
- ram_wdata  out  Data_Width  to the RAM write data.
- ram_rdata  in  Data_Width  from the RAM read data; reflects the address presented in the previous cycle.

Behaviour:
- Reset:
  - States: IDLE, WR, RD_PRIME, RD_STREAM, DONE.
  - reset_n low asynchronously forces IDLE and clears addr_cnt and remaining.
  - While in reset, all outputs are 0: cmd_ready, busy, done, wr_ready, rd_valid, ram_we, ram_addr, ram_wdata, rd_data.
  - cmd_ready rises on the first edge after release.
- IDLE:
  - cmd_ready=1.
  - Handshake (cmd_valid & cmd_ready at an edge) latches addr_cnt=cmd_addr and remaining=cmd_len.
  - Next state: cmd_len=0 -> DONE; cmd_write=1 -> WR; cmd_write=0 -> RD_PRIME.
- Command acceptance outside IDLE:
  - cmd_valid is ignored in every other state (cmd_ready=0).
  - No queuing.
- WR:
  - wr_ready=1.
  - ram_addr=addr_cnt, ram_wdata=wr_data, ram_we=wr_valid (combinational).
  - Each accepted word: addr_cnt+1 (mod 2**Addr_Width), remaining-1.
  - Word accepted with remaining=1 -> DONE.
  - With wr_valid low the burst stalls indefinitely and ram_we stays 0.
- RD_PRIME:
  - Lasts one cycle; ram_addr=addr_cnt, ram_we=0, rd_valid=0.
  - Next state: RD_STREAM.
- RD_STREAM:
  - rd_valid=1, rd_data=ram_rdata, ram_we=0.
  - Accepted (rd_ready=1) and remaining>1: ram_addr=addr_cnt+1 (mod depth); at the edge addr_cnt advances and remaining decrements. The next word is valid on the next cycle, giving 1 word/cycle throughput.
  - Not accepted: ram_addr=addr_cnt, so rd_data is held stable until accepted.
  - Accepted with remaining=1 -> DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - All RAM outputs idle: ram_we=0, ram_addr=0.
  - Next state: IDLE.
- RAM output values outside WR and read states:
  - ram_addr=0, ram_wdata=0, ram_we=0 in IDLE and DONE.
  - ram_wdata=0 outside WR.
- Wrap-around: a burst crossing the top address continues at 0. cmd_len=2**Addr_Width touches every word exactly once.
- Mutual exclusion:
  - wr_ready and rd_valid are never both high.
  - ram_we is never high outside WR.
- Reset mid-burst:
  - The burst is abandoned and no done pulse is produced.
  - Words already written stay in the RAM; no further writes are issued.
- Latency:
  - Command handshake to first ram_we: the next cycle.
  - Command handshake to first rd_valid: 2 cycles.
  - Last accepted word to done: 1 cycle.

Test Plan (Data_Width=8, Addr_Width=2):
1. Hold reset_n=0 over 3 edges, then release -> every output is 0 during reset; cmd_ready=1 after the first edge.
2. Write burst cmd_addr=1, cmd_len=3, wr_data A1,B2,C3 with wr_valid high continuously -> ram_we high 3 consecutive cycles at ram_addr 1,2,3; done pulses once on the following cycle; then busy=0.
3. Wrap-around: write burst cmd_addr=3, cmd_len=4, data 10,20,30,40 -> writes at addresses 3,0,1,2. Then read burst cmd_addr=3, cmd_len=4 with rd_ready=1 -> rd_valid rises 2 cycles after the handshake; rd_data 10,20,30,40 on consecutive cycles; then done.
4. Read backpressure: read burst cmd_addr=0, cmd_len=4 with rd_ready dropped for 2 cycles after the second word -> rd_data holds the third word while stalled; sequence is exactly mem[0..3] with no skip or duplicate; ram_we stays 0 throughout.
5. Edge commands: cmd_len=0 -> done pulses 1 cycle after the handshake, no ram_we. A second cmd_valid asserted during an active burst -> cmd_ready=0 and the command is never executed.
6. Reset mid-operation: fill mem with 00, then write burst cmd_addr=0, cmd_len=4 with data 55,66,77,88, and assert reset_n=0 after 2 words -> outputs go 0 immediately and no done pulse. After release, read burst cmd_addr=0, cmd_len=4 returns 55,66,00,00.
